pwm_demod: RTL and testbench

PWM_DEMOD -- requirements
Module: pwm_demod

---
 rtl/soundgen_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/pwm_demod.sv | 138 +++++++++++++
 tb/tb_pwm_demod.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soundgen_pkg.sv
// Shared definitions for the soundgen PWM blocks.
//   N_DEFAULT     : default sample width in bits
//   FRAME_LEN     : PWM frame length in clocks for the default width (2^N)
//   demod_state_t : decoder state encoding {ACQ, LOCK}
package soundgen_pkg;

    localparam int N_DEFAULT = 8;
    localparam int FRAME_LEN = 2 ** N_DEFAULT;

    typedef enum logic {
        ACQ  = 1'b0,
        LOCK = 1'b1
    } demod_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clocks after d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: recovers the duty value (high clocks per 2^N-clock
// frame) from the soundgen DAC PWM stream.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   en           : decoder enable; low forces ACQ
//   pwm_in       : asynchronous PWM stream
//   sample       : last decoded duty value (saturates at 2^N-1)
//   sample_valid : one-cycle pulse when sample updates
//   locked       : high while in LOCK
//   sync_err     : one-cycle pulse on a rise in the middle of a frame
//   sat          : with sample_valid, frame was high for all 2^N clocks
module pwm_demod
    import soundgen_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int SAT_FLAG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         pwm_in,
    output logic [N-1:0] sample,
    output logic         sample_valid,
    output logic         locked,
    output logic         sync_err,
    output logic         sat
);

    localparam logic [N-1:0] PHASE_LAST = {N{1'b1}};
    localparam logic [N-1:0] PHASE_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   HCNT_ONE   = {{N{1'b0}}, 1'b1};
    localparam logic [N:0]   FULL_COUNT = {1'b1, {N{1'b0}}};

    logic         s;
    logic         s_d;
    logic         rise;
    demod_state_t state;
    demod_state_t state_next;
    logic [N-1:0] phase;
    logic [N-1:0] phase_next;
    logic [N:0]   hcnt;
    logic [N:0]   hcnt_next;
    logic [N:0]   frame_sum;
    logic [N-1:0] sample_next;
    logic         valid_next;
    logic         err_next;
    logic         sat_next;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (s)
    );

    assign rise = s & ~s_d;

    // High count including the current clock; at most 2^N, so N+1 bits suffice.
    assign frame_sum = hcnt + {{N{1'b0}}, s};

    assign locked = (state == LOCK);

    // Next-state and output decode. A rise is only an error strictly inside
    // a frame: at phase 0 it is the expected frame start, and at the last
    // phase frame completion takes priority so the two never collide.
    always_comb begin
        state_next  = state;
        phase_next  = phase;
        hcnt_next   = hcnt;
        sample_next = sample;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        sat_next    = 1'b0;
        if (!en) begin
            state_next = ACQ;
            phase_next = '0;
            hcnt_next  = '0;
        end else begin
            case (state)
                ACQ: begin
                    phase_next = '0;
                    hcnt_next  = '0;
                    if (rise) begin
                        state_next = LOCK;
                        phase_next = PHASE_ONE;
                        hcnt_next  = HCNT_ONE;
                    end
                end
                LOCK: begin
                    if (rise && (phase != '0) && (phase != PHASE_LAST)) begin
                        err_next   = 1'b1;
                        phase_next = PHASE_ONE;
                        hcnt_next  = HCNT_ONE;
                    end else if (phase == PHASE_LAST) begin
                        sample_next = frame_sum[N] ? PHASE_LAST : frame_sum[N-1:0];
                        valid_next  = 1'b1;
                        sat_next    = (SAT_FLAG != 0) && (frame_sum == FULL_COUNT);
                        phase_next  = '0;
                        hcnt_next   = '0;
                    end else begin
                        phase_next = phase + PHASE_ONE;
                        hcnt_next  = frame_sum;
                    end
                end
                default: begin
                    state_next = ACQ;
                    phase_next = '0;
                    hcnt_next  = '0;
                end
            endcase
        end
    end

    // All state and every output (besides the state decode for locked)
    // are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACQ;
            s_d          <= 1'b0;
            phase        <= '0;
            hcnt         <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            sync_err     <= 1'b0;
            sat          <= 1'b0;
        end else begin
            state        <= state_next;
            s_d          <= s;
            phase        <= phase_next;
            hcnt         <= hcnt_next;
            sample       <= sample_next;
            sample_valid <= valid_next;
            sync_err     <= err_next;
            sat          <= sat_next;
        end
    end

endmodule

// File: tb/tb_pwm_demod.sv
// Testbench for pwm_demod (N=8). Randomized PWM frames drive the DUT while a
// frame-level reference model pushes expected sample/sync-error events into
// a scoreboard queue; a negedge monitor pops and compares them.
module tb_pwm_demod;
    import soundgen_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         pwm_in;
    logic [N-1:0] sample;
    logic         sample_valid;
    logic         locked;
    logic         sync_err;
    logic         sat;

    typedef struct {
        int cyc;
        bit is_err;
        int value;
        bit sat;
    } ev_t;

    ev_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model state: a frame starts at m_start; its duty is the
    // number of high synchronized samples within the next FRAME_LEN clocks.
    bit m_locked;
    int m_start;
    int m_cnt;
    int m_sample;
    bit h1, h2, h3;

    pwm_demod #(
        .N        (N),
        .SAT_FLAG (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pwm_in       (pwm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .locked       (locked),
        .sync_err     (sync_err),
        .sat          (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout cyc=%0d required finish", cyc);
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic modelReset();
        m_locked = 1'b0;
        m_cnt    = 0;
        m_sample = 0;
        h1 = 1'b0;
        h2 = 1'b0;
        h3 = 1'b0;
    endtask

    task automatic pushEvent(input bit is_err, input int value, input bit s_flag);
        ev_t ev;
        ev.cyc    = cyc;
        ev.is_err = is_err;
        ev.value  = value;
        ev.sat    = s_flag;
        exp_q.push_back(ev);
    endtask

    // The decoder sees the PWM bit driven two clocks earlier (h2) and the
    // one before that (h3).
    task automatic modelStep(input bit e);
        bit s;
        bit rise;
        int off;
        s    = h2;
        rise = h2 && !h3;
        if (!e) begin
            m_locked = 1'b0;
        end else if (!m_locked) begin
            if (rise) begin
                m_locked = 1'b1;
                m_start  = cyc;
                m_cnt    = 1;
            end
        end else begin
            off = (cyc - m_start) % FRAME_LEN;
            if (rise && off != 0 && off != FRAME_LEN - 1) begin
                pushEvent(1'b1, 0, 1'b0);
                m_start = cyc;
                m_cnt   = 1;
            end else begin
                m_cnt += int'(s);
                if (off == FRAME_LEN - 1) begin
                    m_sample = (m_cnt > FRAME_LEN - 1) ? FRAME_LEN - 1 : m_cnt;
                    pushEvent(1'b0, m_sample, m_cnt == FRAME_LEN);
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit b, input bit e);
        pwm_in = b;
        en     = e;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            modelReset();
        end else begin
            modelStep(e);
            h3 = h2;
            h2 = h1;
            h1 = b;
        end
        #1;
    endtask

    task automatic driveRange(input int t_on, input int from, input int upto, input bit e);
        for (int pos = from; pos < upto; pos++) applyStimulus(pos < t_on, e);
    endtask

    task automatic checkOutput(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, req);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_sample"}, int'(sample), 0);
        checkOutput({tag, "_valid"}, int'(sample_valid), 0);
        checkOutput({tag, "_locked"}, int'(locked), 0);
        checkOutput({tag, "_sync_err"}, int'(sync_err), 0);
        checkOutput({tag, "_sat"}, int'(sat), 0);
    endtask

    // Scoreboard monitor: every output event must match the queue head in
    // cycle, kind, value and sat; an expected event that passes unseen fails.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL missing_event cyc=%0d got=none required=%s@%0d value=%0d",
                         cyc, exp_q[0].is_err ? "sync_err" : "sample_valid",
                         exp_q[0].cyc, exp_q[0].value);
                void'(exp_q.pop_front());
            end
            if (sample_valid || sync_err) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_event cyc=%0d got valid=%0b err=%0b sample=%0d required=none",
                             cyc, sample_valid, sync_err, sample);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    if (ev.cyc != cyc || sync_err != ev.is_err || sample_valid == ev.is_err ||
                        (!ev.is_err && (int'(sample) != ev.value || sat != ev.sat))) begin
                        miscompares++;
                        $display("[TB] FAIL event cyc=%0d got valid=%0b err=%0b sample=%0d sat=%0b required cyc=%0d err=%0b sample=%0d sat=%0b",
                                 cyc, sample_valid, sync_err, sample, sat,
                                 ev.cyc, ev.is_err, ev.value, ev.sat);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        int held;
        rst_n  = 1'b0;
        en     = 1'b0;
        pwm_in = 1'b0;
        modelReset();
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkAllZero("reset");
        rst_n = 1'b1;

        $display("[TB] lock on t_on=127 frames");
        repeat (5 + $urandom_range(0, 20)) applyStimulus(1'b0, 1'b1);
        repeat (4) driveRange(127, 0, FRAME_LEN, 1'b1);
        checkOutput("locked_after_127", int'(locked), 1);
        checkOutput("sample_127", int'(sample), 127);

        $display("[TB] t_on=10 then constant low");
        repeat (2) driveRange(10, 0, FRAME_LEN, 1'b1);
        repeat (3) driveRange(0, 0, FRAME_LEN, 1'b1);
        checkOutput("locked_const_low", int'(locked), 1);
        checkOutput("sample_const_low", int'(sample), 0);

        $display("[TB] constant high");
        repeat (3) driveRange(FRAME_LEN, 0, FRAME_LEN, 1'b1);
        checkOutput("sample_const_high", int'(sample), FRAME_LEN - 1);

        $display("[TB] random duty frames");
        repeat (5) driveRange($urandom_range(1, FRAME_LEN - 1), 0, FRAME_LEN, 1'b1);

        $display("[TB] extra rise at phase 40");
        driveRange(20, 0, 40, 1'b1);
        repeat (2) driveRange($urandom_range(1, FRAME_LEN - 1), 0, FRAME_LEN, 1'b1);
        checkOutput("locked_after_realign", int'(locked), 1);

        $display("[TB] enable drop mid-frame");
        t = $urandom_range(1, 50);
        driveRange(t, 0, 60, 1'b1);
        held = m_sample;
        driveRange(t, 60, 90, 1'b0);
        checkOutput("locked_en_low", int'(locked), 0);
        checkOutput("sample_held_en_low", int'(sample), held);
        driveRange(t, 90, FRAME_LEN, 1'b1);
        repeat (2) driveRange($urandom_range(1, FRAME_LEN - 1), 0, FRAME_LEN, 1'b1);
        checkOutput("relocked", int'(locked), 1);

        $display("[TB] async reset mid-frame");
        t = $urandom_range(1, 99);
        driveRange(t, 0, 102, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAllZero("async_reset");
        driveRange(t, 102, 110, 1'b1);
        rst_n = 1'b1;
        driveRange(t, 110, FRAME_LEN, 1'b1);
        repeat (3) driveRange($urandom_range(1, FRAME_LEN - 1), 0, FRAME_LEN, 1'b1);
        checkOutput("locked_after_reset", int'(locked), 1);

        repeat (FRAME_LEN + 20) applyStimulus(1'b0, 1'b1);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
